// File: rtl/dca_register_file.sv
// DCA register file: decodes CLUT colour writes into a small FIFO toward the CLUT RAM
// and holds shadow display-control registers that are committed to the active outputs on apply.
module dca_register_file #(
  parameter int unit_index = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  register_adr,
  input  logic [23:0] register_data,
  input  logic        register_write,
  input  logic        apply,
  output logic        clut_we,
  output logic [7:0]  clut_addr,
  output logic [23:0] clut_data,
  input  logic        clut_ack,
  output logic [3:0]  icm,
  output logic [3:0]  transparency_ctrl,
  output logic [23:0] transparent_color,
  output logic [23:0] mask_color,
  output logic        clut_overflow
);

  localparam int FIFO_DEPTH = 4;

  logic [1:0]  bank_q, bank_d;
  logic [3:0]  icm_shadow_q, icm_shadow_d;
  logic [3:0]  tc_shadow_q, tc_shadow_d;
  logic [23:0] tcol_shadow_q, tcol_shadow_d;
  logic [23:0] mask_shadow_q, mask_shadow_d;

  logic [3:0]  icm_q, tc_q;
  logic [23:0] tcol_q, mask_q;
  logic        overflow_q, overflow_d;

  logic [31:0] fifo_mem_q [FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;

  logic        push_req;
  logic        pop;
  logic        push_ok;
  logic [3:0]  icm_field;

  // The ICM nibble this instance owns inside the 0x40 word.
  generate
    if (unit_index == 0) begin : g_plane_a
      assign icm_field = register_data[3:0];
    end else begin : g_plane_b
      assign icm_field = register_data[11:8];
    end
  endgenerate

  assign push_req = register_write && !register_adr[6];
  assign pop      = (count_q != 3'd0) && clut_ack;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_ok  = push_req && ((count_q != 3'd4) || pop);

  always_comb begin
    bank_d        = bank_q;
    icm_shadow_d  = icm_shadow_q;
    tc_shadow_d   = tc_shadow_q;
    tcol_shadow_d = tcol_shadow_q;
    mask_shadow_d = mask_shadow_q;
    if (register_write) begin
      case (register_adr)
        7'h40:   icm_shadow_d  = icm_field;
        7'h41:   tc_shadow_d   = register_data[3:0];
        7'h43:   bank_d        = register_data[1:0];
        7'h47:   tcol_shadow_d = register_data;
        7'h49:   mask_shadow_d = register_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q        <= 2'd0;
      icm_shadow_q  <= 4'd0;
      tc_shadow_q   <= 4'd0;
      tcol_shadow_q <= 24'd0;
      mask_shadow_q <= 24'd0;
      icm_q         <= 4'd0;
      tc_q          <= 4'd0;
      tcol_q        <= 24'd0;
      mask_q        <= 24'd0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
    end else begin
      bank_q        <= bank_d;
      icm_shadow_q  <= icm_shadow_d;
      tc_shadow_q   <= tc_shadow_d;
      tcol_shadow_q <= tcol_shadow_d;
      mask_shadow_q <= mask_shadow_d;
      // Committing the next-state shadows lets a same-cycle write win over apply.
      if (apply) begin
        icm_q  <= icm_shadow_d;
        tc_q   <= tc_shadow_d;
        tcol_q <= tcol_shadow_d;
        mask_q <= mask_shadow_d;
      end
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_q == 2'(gi))) begin
          fifo_mem_q[gi] <= {bank_q, register_adr[5:0], register_data};
        end
      end
    end
  endgenerate

  assign clut_we           = (count_q != 3'd0);
  assign clut_addr         = fifo_mem_q[rd_ptr_q][31:24];
  assign clut_data         = fifo_mem_q[rd_ptr_q][23:0];
  assign icm               = icm_q;
  assign transparency_ctrl = tc_q;
  assign transparent_color = tcol_q;
  assign mask_color        = mask_q;
  assign clut_overflow     = overflow_q;

endmodule

// File: tb/tb_dca_register_file.sv
// Directed bench for dca_register_file: two instances (plane A and plane B) share all inputs.
module tb_dca_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  register_adr;
  logic [23:0] register_data;
  logic        register_write;
  logic        apply;
  logic        clut_ack;

  logic        clut_we0, clut_we1;
  logic [7:0]  clut_addr0, clut_addr1;
  logic [23:0] clut_data0, clut_data1;
  logic [3:0]  icm0, icm1;
  logic [3:0]  tc0, tc1;
  logic [23:0] tcol0, tcol1;
  logic [23:0] mask0, mask1;
  logic        ovf0, ovf1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dca_register_file #(.unit_index(0)) dut0 (
    .clk(clk), .reset(reset), .register_adr(register_adr), .register_data(register_data),
    .register_write(register_write), .apply(apply), .clut_we(clut_we0), .clut_addr(clut_addr0),
    .clut_data(clut_data0), .clut_ack(clut_ack), .icm(icm0), .transparency_ctrl(tc0),
    .transparent_color(tcol0), .mask_color(mask0), .clut_overflow(ovf0)
  );

  dca_register_file #(.unit_index(1)) dut1 (
    .clk(clk), .reset(reset), .register_adr(register_adr), .register_data(register_data),
    .register_write(register_write), .apply(apply), .clut_we(clut_we1), .clut_addr(clut_addr1),
    .clut_data(clut_data1), .clut_ack(clut_ack), .icm(icm1), .transparency_ctrl(tc1),
    .transparent_color(tcol1), .mask_color(mask1), .clut_overflow(ovf1)
  );

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [6:0] adr, input logic [23:0] data, input logic with_apply);
    register_adr   = adr;
    register_data  = data;
    register_write = 1'b1;
    apply          = with_apply;
    tick();
    register_write = 1'b0;
    apply          = 1'b0;
  endtask

  task automatic do_apply();
    apply = 1'b1;
    tick();
    apply = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; register_adr = '0; register_data = '0;
    register_write = 1'b0; apply = 1'b0; clut_ack = 1'b1;
    #2;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_clut_we", {31'd0, clut_we0}, 32'd0);
    check_eq("rst_icm", {24'd0, icm0, icm1}, 32'd0);
    check_eq("rst_tc", {28'd0, tc0}, 32'd0);
    check_eq("rst_tcol", {8'd0, tcol0}, 32'd0);
    check_eq("rst_mask", {8'd0, mask0}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf0}, 32'd0);

    // Bank select applies to the very next CLUT write; single-cycle transfer with ack=1
    reg_write(7'h43, 24'h000002, 1'b0);
    reg_write(7'h05, 24'h123456, 1'b0);
    check_eq("bank_we", {31'd0, clut_we0}, 32'd1);
    check_eq("bank_addr", {24'd0, clut_addr0}, 32'h85);
    check_eq("bank_data", {8'd0, clut_data0}, 32'h123456);
    tick();
    check_eq("bank_we_one_cycle", {31'd0, clut_we0}, 32'd0);

    // ICM field per instance, held until apply
    reg_write(7'h40, 24'h000A03, 1'b0);
    check_eq("icm_no_apply", {24'd0, icm0, icm1}, 32'd0);
    do_apply();
    check_eq("icm_u0", {28'd0, icm0}, 32'h3);
    check_eq("icm_u1", {28'd0, icm1}, 32'hA);

    // Write in the same cycle as apply wins
    reg_write(7'h47, 24'hABCDEF, 1'b1);
    check_eq("tcol_same_cycle", {8'd0, tcol0}, 32'hABCDEF);
    reg_write(7'h41, 24'hFFFFF5, 1'b0);
    reg_write(7'h49, 24'h13579B, 1'b0);
    check_eq("mask_before_apply", {8'd0, mask0}, 32'd0);
    do_apply();
    check_eq("tc_apply", {28'd0, tc0}, 32'h5);
    check_eq("mask_apply", {8'd0, mask0}, 32'h13579B);
    // Unmapped address leaves everything alone
    reg_write(7'h42, 24'hFFFFFF, 1'b1);
    check_eq("ignored_tc", {28'd0, tc0}, 32'h5);
    check_eq("ignored_icm", {24'd0, icm0, icm1}, 32'h3A);
    check_eq("ignored_tcol", {8'd0, tcol0}, 32'hABCDEF);
    check_eq("ignored_we", {31'd0, clut_we0}, 32'd0);

    // Overflow: 5 writes with ack held low
    reg_write(7'h43, 24'h000000, 1'b0);
    clut_ack = 1'b0;
    for (int i = 0; i < 4; i++) reg_write(7'(i), 24'h100 + 24'(i), 1'b0);
    check_eq("full_no_ovf", {31'd0, ovf0}, 32'd0);
    reg_write(7'h04, 24'h104, 1'b0);
    check_eq("ovf_set", {31'd0, ovf0}, 32'd1);
    tick();
    check_eq("stall_addr", {24'd0, clut_addr0}, 32'h00);
    check_eq("stall_data", {8'd0, clut_data0}, 32'h100);
    clut_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("drain_we_%0d", i), {31'd0, clut_we0}, 32'd1);
      check_eq($sformatf("drain_addr_%0d", i), {24'd0, clut_addr0}, 32'(i));
      check_eq($sformatf("drain_data_%0d", i), {8'd0, clut_data0}, 32'h100 + 32'(i));
      tick();
    end
    check_eq("drain_done", {31'd0, clut_we0}, 32'd0);
    check_eq("ovf_sticky", {31'd0, ovf0}, 32'd1);

    // Push and pop together while full: no overflow, still four deep
    do_reset();
    check_eq("ovf_cleared", {31'd0, ovf0}, 32'd0);
    clut_ack = 1'b0;
    for (int i = 0; i < 4; i++) reg_write(7'h10 + 7'(i), 24'h200 + 24'(i), 1'b0);
    clut_ack = 1'b1;
    reg_write(7'h14, 24'h204, 1'b0);
    clut_ack = 1'b0;
    check_eq("full_pushpop_ovf", {31'd0, ovf0}, 32'd0);
    check_eq("full_pushpop_count", {29'd0, dut0.count_q}, 32'd4);
    check_eq("full_pushpop_head", {24'd0, clut_addr0}, 32'h11);
    clut_ack = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_eq($sformatf("pp_addr_%0d", i), {24'd0, clut_addr0}, 32'h10 + 32'(i));
      check_eq($sformatf("pp_data_%0d", i), {8'd0, clut_data0}, 32'h200 + 32'(i));
      tick();
    end
    check_eq("pp_done", {31'd0, clut_we0}, 32'd0);

    // Reset with two entries pending and non-zero active registers
    reg_write(7'h40, 24'h000505, 1'b1);
    reg_write(7'h49, 24'h55AA55, 1'b1);
    check_eq("pre_rst_mask", {8'd0, mask0}, 32'h55AA55);
    clut_ack = 1'b0;
    reg_write(7'h20, 24'h300, 1'b0);
    reg_write(7'h21, 24'h301, 1'b0);
    check_eq("pre_rst_we", {31'd0, clut_we0}, 32'd1);
    do_reset();
    clut_ack = 1'b1;
    check_eq("mid_rst_we", {31'd0, clut_we0}, 32'd0);
    check_eq("mid_rst_icm", {24'd0, icm0, icm1}, 32'd0);
    check_eq("mid_rst_mask", {8'd0, mask0}, 32'd0);
    check_eq("mid_rst_tcol", {8'd0, tcol0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("post_rst_idle_%0d", i), {31'd0, clut_we0}, 32'd0);
    end
    // Bank also cleared: the next CLUT write lands in bank 0
    reg_write(7'h07, 24'h0000AA, 1'b0);
    check_eq("post_rst_bank", {24'd0, clut_addr0}, 32'h07);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dca_register_file.md
DCA_REGISTER_FILE -- requirements
Module: dca_register_file

Interface
REQ-001 Parameter: unit_index, 0, selects the ICM field this instance decodes (0 = plane A bits[3:0], 1 = plane B bits[11:8]).
REQ-002 clk  in  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 register_adr  in  7  register address; bit 7 of the instruction word is already stripped.
REQ-005 register_data  in  24  register write data.
REQ-006 register_write  in  1  single-cycle write strobe from the ICA/DCA controller.
REQ-007 apply  in  1  single-cycle pulse marking the end of HBLANK; shadow registers are committed on it.
REQ-008 clut_we  out  1  CLUT RAM write request, held until acknowledged.
REQ-009 clut_addr  out  8  CLUT RAM entry address.
REQ-010 clut_data  out  24  CLUT RAM write data, RGB 8:8:8.
REQ-011 clut_ack  in  1  CLUT RAM accepted the current write this cycle.
REQ-012 icm  out  4  active image coding method.
REQ-013 transparency_ctrl  out  4  active transparency control, from register 0x41 data[3:0].
REQ-014 transparent_color  out  24  active transparent colour key.
REQ-015 mask_color  out  24  active mask colour.
REQ-016 clut_overflow  out  1  sticky flag: a CLUT write was dropped.

Function
REQ-017 Addresses 0x00-0x3F SHALL be CLUT colour writes; the entry address is {bank[1:0], register_adr[5:0]} and the data is register_data.
REQ-018 Address 0x43 SHALL load bank from register_data[1:0] in the cycle after the strobe, and the new bank SHALL apply to the next CLUT write, with no wait for apply.
REQ-019 Writes to the shadow registers SHALL be as follows:
- 0x40 loads icm_shadow from data[3:0] when unit_index=0, or from data[11:8] when unit_index=1.
- 0x41 loads tc_shadow from data[3:0].
- 0x47 loads the transparent-colour shadow.
- 0x49 loads the mask-colour shadow.
REQ-020 All other addresses SHALL be ignored with no state change.
REQ-021 On apply, all four shadows SHALL be copied to the active outputs, which become visible 1 cycle after the apply edge.
REQ-022 If register_write and apply occur in the same cycle, the write SHALL land in its shadow and the active output SHALL take the new value, i.e. the write wins.
REQ-023 CLUT writes SHALL enter a 4-entry FIFO holding {addr, data}.
REQ-024 The head entry SHALL drive clut_addr/clut_data with clut_we=1 whenever the FIFO is non-empty.
REQ-025 The head entry SHALL be popped on clut_we && clut_ack.
REQ-026 Minimum latency SHALL be 1 cycle: strobe at cycle N gives clut_we=1 at cycle N+1 when the FIFO was empty.
REQ-027 With simultaneous push and pop while full, the FIFO SHALL accept the push and stay full with no overflow.
REQ-028 A push to a full FIFO without a pop SHALL drop the new entry and set clut_overflow; the flag SHALL clear only on reset.
REQ-029 Read/write pointers SHALL be 2-bit and wrap modulo 4; occupancy SHALL be a 3-bit count in the range 0-4.
REQ-030 clut_addr/clut_data SHALL remain stable while clut_we=1 and clut_ack=0.

Reset
REQ-031 On reset, bank, all shadows, icm, transparency_ctrl, transparent_color, mask_color and clut_overflow SHALL be 0.
REQ-032 On reset, the FIFO SHALL be emptied and clut_we SHALL be 0 in the next cycle.
REQ-033 Reset asserted mid-transfer SHALL discard pending CLUT entries without completing them.

Verification
REQ-034 Scenario: write 0x43=0x000002, then 0x05=0x123456, with clut_ack tied 1 -> one cycle of clut_we with clut_addr=0x85, clut_data=0x123456.
REQ-035 Scenario: write 0x40=0x000A03 on instances with unit_index 0 and 1, no apply -> icm stays 0; after apply -> icm=3 and icm=0xA respectively.
REQ-036 Scenario: clut_ack=0; 5 CLUT writes to 0x00-0x04 -> clut_overflow=1; release ack -> exactly addresses 0x00-0x03 emitted in order.
REQ-037 Scenario: write 0x47=0xABCDEF in the same cycle as apply -> transparent_color=0xABCDEF on the next cycle.
REQ-038 Scenario: FIFO full, clut_ack=1, new write -> no overflow, count stays 4.
REQ-039 Scenario: 2 entries pending, reset pulse -> clut_we=0, all outputs 0, no further CLUT writes.
